dmx_frame_sequencer: RTL and testbench

- Sequences one complete DMX512 output frame on a single serial line: BREAK, mark-after-break (MAB), start-code slot, then NUM_SLOTS channel slots at 250 kbaud.
- Generates its own bit-rate timing from sysclk and fetches channel bytes from the channel buffer RAM through a 1-cycle-latency read port.
- Sits between the channel buffer and the RS-485 driver pin. It is the scheduler that owns the line timing and slot order.

---
 rtl/dmx_frame_sequencer.sv | 177 +++++++++++++++++
 tb/tb_dmx_frame_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmx_frame_sequencer.sv
// DMX512 frame sequencer: drives BREAK, MAB, start-code slot and NUM_SLOTS channel
// slots on one serial line, fetching channel bytes from a 1-cycle-latency buffer.
module dmx_frame_sequencer #(
  parameter int CLKS_PER_BIT = 192,
  parameter int BREAK_BITS   = 25,
  parameter int MAB_BITS     = 3,
  parameter int NUM_SLOTS    = 512,
  parameter int MTBF_BITS    = 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       start,
  input  logic       continuous,
  input  logic [7:0] start_code,
  output logic       rd_en,
  output logic [8:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int TW       = $clog2(CLKS_PER_BIT);
  localparam int MAX_A    = (BREAK_BITS > MAB_BITS) ? BREAK_BITS : MAB_BITS;
  localparam int MAX_B    = (MTBF_BITS > 11) ? MTBF_BITS : 11;
  localparam int MAX_BITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int BW       = $clog2(MAX_BITS + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BREAK_LAST = BW'(BREAK_BITS - 1);
  localparam logic [BW-1:0] MAB_LAST   = BW'(MAB_BITS - 1);
  localparam logic [BW-1:0] MTBF_LAST  = BW'((MTBF_BITS > 0) ? MTBF_BITS - 1 : 0);
  localparam logic [BW-1:0] LAST_DATA  = BW'(8);
  localparam logic [BW-1:0] LAST_STOP  = BW'(10);
  localparam logic [9:0]    LAST_SLOT  = 10'(NUM_SLOTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_MAB,
    S_SLOT,
    S_MTBF
  } state_e;

  state_e          state_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [BW-1:0]   bit_q;
  logic [9:0]      slot_q;
  logic [7:0]      shift_q;
  logic [7:0]      next_byte_q;
  logic [7:0]      start_code_q;
  logic            rd_pending_q;
  logic            tx_q, busy_q, frame_done_q, rd_en_q;
  logic [8:0]      rd_addr_q;

  logic            bit_wrap;
  logic            frame_end;
  logic            go_break;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    bit_wrap  = (timer_q == TIMER_LAST);
    timer_d   = '0;
    if (state_q != S_IDLE && !bit_wrap) timer_d = timer_q + 1'b1;

    frame_end = (state_q == S_SLOT) && bit_wrap && (bit_q == LAST_STOP) &&
                (slot_q == LAST_SLOT);
    go_break  = ((state_q == S_IDLE) && (start || continuous)) ||
                ((state_q == S_MTBF) && bit_wrap && (bit_q == MTBF_LAST)) ||
                (frame_end && continuous && (MTBF_BITS == 0));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bit_q        <= '0;
      slot_q       <= '0;
      shift_q      <= '0;
      next_byte_q  <= '0;
      start_code_q <= '0;
      rd_pending_q <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      timer_q      <= timer_d;
      frame_done_q <= 1'b0;
      rd_en_q      <= 1'b0;
      // Buffer data arrives the cycle after the strobe.
      rd_pending_q <= rd_en_q;
      if (rd_pending_q) next_byte_q <= rd_data;

      if (go_break) begin
        state_q      <= S_BREAK;
        bit_q        <= '0;
        tx_q         <= 1'b0;
        busy_q       <= 1'b1;
        start_code_q <= start_code;
        frame_done_q <= frame_end;
      end else if (bit_wrap) begin
        case (state_q)
          S_BREAK: begin
            if (bit_q == BREAK_LAST) begin
              state_q <= S_MAB;
              bit_q   <= '0;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
          S_MAB: begin
            if (bit_q == MAB_LAST) begin
              state_q <= S_SLOT;
              bit_q   <= '0;
              slot_q  <= '0;
              shift_q <= start_code_q;
              tx_q    <= 1'b0;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
          S_SLOT: begin
            if (bit_q == LAST_STOP) begin
              bit_q <= '0;
              if (frame_end) begin
                frame_done_q <= 1'b1;
                tx_q         <= 1'b1;
                if (continuous) begin
                  state_q <= S_MTBF;
                end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                end
              end else begin
                slot_q  <= slot_q + 10'd1;
                shift_q <= next_byte_q;
                tx_q    <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              if (bit_q < LAST_DATA) begin
                tx_q    <= shift_q[0];
                shift_q <= {1'b0, shift_q[7:1]};
              end else begin
                tx_q <= 1'b1;
              end
              // Entering the first stop bit: prefetch the byte for the next slot.
              if (bit_q == LAST_DATA && slot_q < LAST_SLOT) begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= slot_q[8:0];
              end
            end
          end
          S_MTBF: bit_q <= bit_q + 1'b1;
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_dmx_frame_sequencer.sv
// Bench for dmx_frame_sequencer: a 3-slot instance for the frame/continuous/reset
// cases and a 512-slot instance for the full-size frame, both against a bit-level model.
module tb_dmx_frame_sequencer;

  localparam int CPB       = 4;
  localparam int SMALL_LEN = 288;
  localparam int BIG_LEN   = 22684;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       start_a, cont_a, start_b, cont_b;
  logic [7:0] start_code;
  logic       rd_en_a, rd_en_b, tx_a, tx_b, busy_a, busy_b, fd_a, fd_b;
  logic [8:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;

  logic [7:0] mem [512];
  int         sel;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 sysclk = ~sysclk;

  dmx_frame_sequencer #(
    .CLKS_PER_BIT(CPB), .BREAK_BITS(25), .MAB_BITS(3), .NUM_SLOTS(3), .MTBF_BITS(2)
  ) dut_a (
    .sysclk(sysclk), .reset(reset), .start(start_a), .continuous(cont_a),
    .start_code(start_code), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
  );

  dmx_frame_sequencer #(
    .CLKS_PER_BIT(CPB), .BREAK_BITS(25), .MAB_BITS(3), .NUM_SLOTS(512), .MTBF_BITS(2)
  ) dut_b (
    .sysclk(sysclk), .reset(reset), .start(start_b), .continuous(cont_b),
    .start_code(start_code), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .tx(tx_b), .busy(busy_b), .frame_done(fd_b)
  );

  // Channel buffer: registered read, data valid the cycle after rd_en.
  always @(posedge sysclk) begin
    if (rd_en_a) rd_data_a <= mem[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem[rd_addr_b];
  end

  logic       mon_tx, mon_busy, mon_fd, mon_rd_en;
  logic [8:0] mon_rd_addr;
  assign mon_tx      = (sel == 0) ? tx_a      : tx_b;
  assign mon_busy    = (sel == 0) ? busy_a    : busy_b;
  assign mon_fd      = (sel == 0) ? fd_a      : fd_b;
  assign mon_rd_en   = (sel == 0) ? rd_en_a   : rd_en_b;
  assign mon_rd_addr = (sel == 0) ? rd_addr_a : rd_addr_b;

  typedef struct {
    logic [7:0] sc;
    logic [7:0] d0, d1, d2;
    int         exp_len;
  } vec_t;
  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Line level k cycles after frame acceptance, straight from the frame format.
  function automatic logic exp_tx(input int k, input logic [7:0] sc);
    int b, s, p;
    logic [7:0] byte_v;
    b = k / CPB;
    if (b < 25) return 1'b0;
    if (b < 28) return 1'b1;
    s = (b - 28) / 11;
    p = (b - 28) % 11;
    byte_v = (s == 0) ? sc : mem[s-1];
    if (p == 0) return 1'b0;
    if (p <= 8) return byte_v[p-1];
    return 1'b1;
  endfunction

  // Called on the negedge of the first cycle after acceptance; returns on the
  // negedge of cycle len, where frame_done must be high.
  task automatic watch_frame(input string tag, input int nslots, input int len,
                             input logic [7:0] sc, input bit expect_cont);
    int tx_err = 0, first_err = -1, rd_cnt = 0, rd_err = 0, busy_err = 0, fd_err = 0;
    for (int k = 0; k < len; k++) begin
      if (mon_tx !== exp_tx(k, sc)) begin
        if (tx_err == 0) first_err = k;
        tx_err++;
      end
      if (mon_busy !== 1'b1) busy_err++;
      if (mon_fd !== 1'b0) fd_err++;
      if (mon_rd_en === 1'b1) begin
        if (k != (37 + 11 * rd_cnt) * CPB || mon_rd_addr !== 9'(rd_cnt)) rd_err++;
        rd_cnt++;
      end else if (mon_rd_en !== 1'b0) begin
        rd_err++;
      end
      @(negedge sysclk);
    end
    check($sformatf("%s tx errors (first bad cycle %0d)", tag, first_err), tx_err, 0);
    check({tag, " read count"}, rd_cnt, nslots);
    check({tag, " read addr/timing errors"}, rd_err, 0);
    check({tag, " busy drop"}, busy_err, 0);
    check({tag, " early frame_done"}, fd_err, 0);
    check({tag, " frame_done at end"}, mon_fd, 1);
    check({tag, " busy at end"}, mon_busy, expect_cont);
    check({tag, " tx at end"}, mon_tx, 1);
  endtask

  task automatic start_frame(input int which, input logic [7:0] sc);
    @(negedge sysclk);
    sel        = which;
    start_code = sc;
    if (which == 0) start_a = 1'b1;
    else            start_b = 1'b1;
    @(negedge sysclk);
    start_a    = 1'b0;
    start_b    = 1'b0;
    start_code = ~sc;
  endtask

  task automatic idle_check(input string tag, input int n);
    int err = 0;
    for (int i = 0; i < n; i++) begin
      if (mon_tx !== 1'b1 || mon_busy !== 1'b0 || mon_rd_en !== 1'b0 || mon_fd !== 1'b0) err++;
      @(negedge sysclk);
    end
    check({tag, " activity while idle"}, err, 0);
  endtask

  initial begin
    logic [7:0] sc;
    int mtbf_err;

    reset = 1'b0; start_a = 1'b0; cont_a = 1'b0; start_b = 1'b0; cont_b = 1'b0;
    start_code = 8'h00; sel = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;

    vecs[0] = '{sc: 8'h00, d0: 8'h01, d1: 8'hA5, d2: 8'hFF, exp_len: SMALL_LEN};
    vecs[1] = '{sc: 8'hFF, d0: 8'h00, d1: 8'h00, d2: 8'h00, exp_len: SMALL_LEN};
    vecs[2] = '{sc: 8'h55, d0: 8'hAA, d1: 8'h80, d2: 8'h01, exp_len: SMALL_LEN};

    repeat (3) @(negedge sysclk);
    check("reset tx", tx_a, 1);
    check("reset busy", busy_a, 0);
    check("reset frame_done", fd_a, 0);
    check("reset rd_en", rd_en_a, 0);
    check("reset rd_addr", rd_addr_a, 0);
    reset = 1'b1;
    idle_check("after reset", 10);

    for (int i = 0; i < 3; i++) begin
      mem[0] = vecs[i].d0; mem[1] = vecs[i].d1; mem[2] = vecs[i].d2;
      start_frame(0, vecs[i].sc);
      watch_frame($sformatf("vec%0d", i), 3, vecs[i].exp_len, vecs[i].sc, 1'b0);
      @(negedge sysclk);
      check($sformatf("vec%0d frame_done single cycle", i), fd_a, 0);
      check($sformatf("vec%0d busy after", i), busy_a, 0);
    end

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
      sc = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge sysclk);
      start_frame(0, sc);
      watch_frame($sformatf("rand%0d", r), 3, SMALL_LEN, sc, 1'b0);
    end

    // Continuous mode: two frames, start code re-sampled at the second BREAK.
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    @(negedge sysclk);
    sel = 0; start_code = 8'h00; cont_a = 1'b1;
    @(negedge sysclk);
    start_code = 8'hCC;
    watch_frame("cont f1", 3, SMALL_LEN, 8'h00, 1'b1);
    mtbf_err = 0;
    for (int j = 0; j < 8; j++) begin
      if (tx_a !== 1'b1 || busy_a !== 1'b1) mtbf_err++;
      @(negedge sysclk);
    end
    check("mtbf tx high / busy held", mtbf_err, 0);
    fork
      watch_frame("cont f2", 3, SMALL_LEN, 8'hCC, 1'b0);
      begin
        repeat (120) @(negedge sysclk);
        cont_a = 1'b0;
        repeat (85) @(negedge sysclk);
        start_a = 1'b1;
        @(negedge sysclk);
        start_a = 1'b0;
      end
    join
    @(negedge sysclk);
    idle_check("no extra frame", 40);

    // Reset during the data bits of slot 1.
    mem[0] = 8'h00; mem[1] = 8'h9C; mem[2] = 8'h71;
    start_frame(0, 8'h3C);
    repeat (165) @(negedge sysclk);
    check("pre-reset tx low", tx_a, 0);
    #2 reset = 1'b0;
    #1;
    check("async reset tx", tx_a, 1);
    check("async reset busy", busy_a, 0);
    check("async reset rd_en", rd_en_a, 0);
    @(negedge sysclk);
    @(negedge sysclk);
    reset = 1'b1;
    idle_check("after mid-frame reset", 30);
    mem[0] = 8'hE7;
    start_frame(0, 8'h81);
    watch_frame("post-reset frame", 3, SMALL_LEN, 8'h81, 1'b0);

    // Full 512-slot frame.
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    sc = 8'($urandom);
    start_frame(1, sc);
    watch_frame("512 slots", 512, BIG_LEN, sc, 1'b0);
    @(negedge sysclk);
    check("512 slots busy after", busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
